// File: rtl/flow_pkg.sv
// Shared types and helpers for the flow-control merge/split blocks.
//   sel_t        1-bit input selector (SEL_A / SEL_B)
//   run_width()  width of a saturating run counter that must hold 0..burst
package flow_pkg;

    typedef logic sel_t;

    localparam sel_t SEL_A = 1'b0;
    localparam sel_t SEL_B = 1'b1;

    // Never returns 0, so a counter declared with it is always legal.
    function automatic int unsigned run_width(int unsigned burst);
        return ($clog2(burst + 1) < 1) ? 1 : $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/rr_burst_pick.sv
// Two-requester round-robin picker with bounded bursts.
//   clk_i, rst_ni   clock / async active-low reset
//   req_a_i/req_b_i requests from input A / B
//   grant_en_i      the current pick is actually consumed this cycle
//   winner_o        selected requester (SEL_A / SEL_B), valid when has_winner_o
//   has_winner_o    at least one request present
// A contested pick stays with the last winner until it has taken BURST
// consecutive grants, then flips. Uncontested grants update the history too.
module rr_burst_pick
    import flow_pkg::*;
#(
    parameter int unsigned BURST = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic grant_en_i,
    output sel_t winner_o,
    output logic has_winner_o
);

    localparam int unsigned RunW = run_width(BURST);
    localparam logic [RunW-1:0] RunMax = RunW'(BURST);
    localparam logic [RunW-1:0] RunOne = RunW'(1);

    sel_t            last_q, last_d;
    logic [RunW-1:0] run_q, run_d;

    always_comb begin
        has_winner_o = req_a_i | req_b_i;
        if (req_a_i && req_b_i) begin
            winner_o = (run_q < RunMax) ? last_q : ~last_q;
        end else if (req_a_i) begin
            winner_o = SEL_A;
        end else begin
            winner_o = SEL_B;
        end
    end

    always_comb begin
        last_d = last_q;
        run_d  = run_q;
        if (grant_en_i && has_winner_o) begin
            if (winner_o == last_q) begin
                // Saturate rather than wrap so a long run never looks fresh.
                if (run_q != RunMax) begin
                    run_d = run_q + RunOne;
                end
            end else begin
                last_d = winner_o;
                run_d  = RunOne;
            end
        end
    end

    // Reset to "B just finished a full burst" so the first contest goes to A.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= SEL_B;
            run_q  <= RunMax;
        end else begin
            last_q <= last_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/arb_merge.sv
// Two-input arbitrated merge producing a data token (Z) and a winner-id
// token (S) for a downstream Split.
//   clk, reset_n          clock / async active-low reset
//   A_* / B_*             requester channels (data, valid in; ready out)
//   Z_*                   merged payload channel (registered)
//   S_*                   winner id channel, 0=A 1=B (registered)
// Z and S are issued together but drain independently; a new grant needs
// both output slots free.
module arb_merge
    import flow_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BURST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A_data,
    input  logic             A_valid,
    output logic             A_ready,
    input  logic [WIDTH-1:0] B_data,
    input  logic             B_valid,
    output logic             B_ready,
    output logic [WIDTH-1:0] Z_data,
    output logic             Z_valid,
    input  logic             Z_ready,
    output logic             S_data,
    output logic             S_valid,
    input  logic             S_ready
);

    logic [WIDTH-1:0] z_data_q, z_data_d;
    logic             z_valid_q, z_valid_d;
    sel_t             s_data_q, s_data_d;
    logic             s_valid_q, s_valid_d;

    sel_t winner;
    logic has_winner;
    logic slot_free;
    logic grant;

    assign slot_free = (!z_valid_q || Z_ready) && (!s_valid_q || S_ready);
    // reset_n gating keeps the readies low while reset is held.
    assign grant     = slot_free && has_winner && reset_n;

    rr_burst_pick #(
        .BURST (BURST)
    ) u_pick (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .req_a_i      (A_valid),
        .req_b_i      (B_valid),
        .grant_en_i   (grant),
        .winner_o     (winner),
        .has_winner_o (has_winner)
    );

    assign A_ready = grant && (winner == SEL_A);
    assign B_ready = grant && (winner == SEL_B);

    always_comb begin
        z_data_d  = z_data_q;
        z_valid_d = z_valid_q;
        s_data_d  = s_data_q;
        s_valid_d = s_valid_q;
        if (grant) begin
            z_data_d  = (winner == SEL_B) ? B_data : A_data;
            s_data_d  = winner;
            z_valid_d = 1'b1;
            s_valid_d = 1'b1;
        end else begin
            if (Z_ready) begin
                z_valid_d = 1'b0;
            end
            if (S_ready) begin
                s_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_data_q  <= '0;
            z_valid_q <= 1'b0;
            s_data_q  <= SEL_A;
            s_valid_q <= 1'b0;
        end else begin
            z_data_q  <= z_data_d;
            z_valid_q <= z_valid_d;
            s_data_q  <= s_data_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign Z_data  = z_data_q;
    assign Z_valid = z_valid_q;
    assign S_data  = s_data_q;
    assign S_valid = s_valid_q;

endmodule

// File: tb/tb_arb_merge.sv
// Bench for arb_merge: three instances (BURST = 1, 3, 2) share clock/reset.
// A behavioural model tracks every instance each cycle; a vector table and
// hand-written sequences cover the directed corner cases.
module tb_arb_merge;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  a_data[3], b_data[3], z_data[3];
    logic          a_valid[3], a_ready[3], b_valid[3], b_ready[3];
    logic          z_valid[3], z_ready[3], s_data[3], s_valid[3], s_ready[3];

    int burst_of[3] = '{1, 3, 2};

    always #5 clk = ~clk;

    arb_merge #(.WIDTH(W), .BURST(1)) u_b1 (
        .clk(clk), .reset_n(reset_n),
        .A_data(a_data[0]), .A_valid(a_valid[0]), .A_ready(a_ready[0]),
        .B_data(b_data[0]), .B_valid(b_valid[0]), .B_ready(b_ready[0]),
        .Z_data(z_data[0]), .Z_valid(z_valid[0]), .Z_ready(z_ready[0]),
        .S_data(s_data[0]), .S_valid(s_valid[0]), .S_ready(s_ready[0])
    );

    arb_merge #(.WIDTH(W), .BURST(3)) u_b3 (
        .clk(clk), .reset_n(reset_n),
        .A_data(a_data[1]), .A_valid(a_valid[1]), .A_ready(a_ready[1]),
        .B_data(b_data[1]), .B_valid(b_valid[1]), .B_ready(b_ready[1]),
        .Z_data(z_data[1]), .Z_valid(z_valid[1]), .Z_ready(z_ready[1]),
        .S_data(s_data[1]), .S_valid(s_valid[1]), .S_ready(s_ready[1])
    );

    arb_merge #(.WIDTH(W), .BURST(2)) u_b2 (
        .clk(clk), .reset_n(reset_n),
        .A_data(a_data[2]), .A_valid(a_valid[2]), .A_ready(a_ready[2]),
        .B_data(b_data[2]), .B_valid(b_valid[2]), .B_ready(b_ready[2]),
        .Z_data(z_data[2]), .Z_valid(z_valid[2]), .Z_ready(z_ready[2]),
        .S_data(s_data[2]), .S_valid(s_valid[2]), .S_ready(s_ready[2])
    );

    // Reference model state: who won last, how many grants in a row.
    int           m_last[3], m_run[3];
    bit           m_zv[3], m_sv[3], m_sd[3];
    logic [W-1:0] m_zd[3];
    bit           acc_a[3], acc_b[3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit av, bv, zr, sr;
        bit ea, eb, ezv, esv, esd;
    } row_t;
    row_t tbl[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_last[k] = 1;
            m_run[k]  = burst_of[k];
            m_zv[k]   = 0;
            m_sv[k]   = 0;
            m_sd[k]   = 0;
            m_zd[k]   = '0;
            acc_a[k]  = 0;
            acc_b[k]  = 0;
        end
    endfunction

    function automatic void idle_all();
        for (int k = 0; k < 3; k++) begin
            a_valid[k] = 0;
            b_valid[k] = 0;
            z_ready[k] = 1;
            s_ready[k] = 1;
        end
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic pre_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            int w;
            bit free, gr;
            w = -1;
            if (a_valid[k] && b_valid[k])
                w = (m_run[k] < burst_of[k]) ? m_last[k] : 1 - m_last[k];
            else if (a_valid[k])
                w = 0;
            else if (b_valid[k])
                w = 1;
            free = (!m_zv[k] || z_ready[k]) && (!m_sv[k] || s_ready[k]);
            gr   = free && (w >= 0);
            acc_a[k] = gr && (w == 0);
            acc_b[k] = gr && (w == 1);
            check($sformatf("a_ready[%0d]", k), a_ready[k], acc_a[k]);
            check($sformatf("b_ready[%0d]", k), b_ready[k], acc_b[k]);
            if (gr) begin
                m_zd[k] = (w == 1) ? b_data[k] : a_data[k];
                m_sd[k] = (w == 1);
                m_zv[k] = 1;
                m_sv[k] = 1;
                if (w == m_last[k]) begin
                    m_run[k] = (m_run[k] + 1 > burst_of[k]) ? burst_of[k] : m_run[k] + 1;
                end else begin
                    m_last[k] = w;
                    m_run[k]  = 1;
                end
            end else begin
                if (z_ready[k]) m_zv[k] = 0;
                if (s_ready[k]) m_sv[k] = 0;
            end
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("z_valid[%0d]", k), z_valid[k], m_zv[k]);
            check($sformatf("s_valid[%0d]", k), s_valid[k], m_sv[k]);
            check($sformatf("z_data[%0d]", k), z_data[k], m_zd[k]);
            check($sformatf("s_data[%0d]", k), s_data[k], m_sd[k]);
        end
    endtask

    task automatic step();
        pre_edge();
        post_edge();
    endtask

    // Hold reset with every requester valid; readies and outputs must stay low.
    task automatic do_reset();
        reset_n = 0;
        for (int k = 0; k < 3; k++) begin
            a_valid[k] = 1;
            b_valid[k] = 1;
            a_data[k]  = {$urandom, $urandom};
            b_data[k]  = {$urandom, $urandom};
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst a_ready[%0d]", k), a_ready[k], 0);
            check($sformatf("rst b_ready[%0d]", k), b_ready[k], 0);
            check($sformatf("rst z_valid[%0d]", k), z_valid[k], 0);
            check($sformatf("rst s_valid[%0d]", k), s_valid[k], 0);
        end
        repeat (2) @(negedge clk);
        model_reset();
        idle_all();
        reset_n = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        tbl[2] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        tbl[3] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        tbl[4] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
        tbl[5] = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[6] = '{0, 1, 1, 1, 0, 1, 1, 1, 1};
        tbl[7] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};

        idle_all();
        model_reset();
        for (int k = 0; k < 3; k++) begin
            a_data[k] = '0;
            b_data[k] = '0;
        end
        @(negedge clk);

        // Reset with requests pending; first grant after release is A everywhere.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a_valid[k] = 1;
            b_valid[k] = 1;
        end
        step();
        for (int k = 0; k < 3; k++) check($sformatf("first grant[%0d]", k), s_data[k], 0);

        // Vector table on the BURST=1 instance: alternation and backpressure.
        do_reset();
        a_data[0] = 64'hAAAA_0000_0000_AAAA;
        b_data[0] = 64'hBBBB_0000_0000_BBBB;
        for (int i = 0; i < 8; i++) begin
            a_valid[0] = tbl[i].av;
            b_valid[0] = tbl[i].bv;
            z_ready[0] = tbl[i].zr;
            s_ready[0] = tbl[i].sr;
            pre_edge();
            check($sformatf("tbl%0d a_ready", i), a_ready[0], tbl[i].ea);
            check($sformatf("tbl%0d b_ready", i), b_ready[0], tbl[i].eb);
            post_edge();
            check($sformatf("tbl%0d z_valid", i), z_valid[0], tbl[i].ezv);
            check($sformatf("tbl%0d s_valid", i), s_valid[0], tbl[i].esv);
            check($sformatf("tbl%0d s_data", i), s_data[0], tbl[i].esd);
        end

        // Strict alternation (BURST=1) and 3-bursts (BURST=3), new data each cycle.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 2; k++) begin
                a_valid[k] = 1;
                b_valid[k] = 1;
                a_data[k]  = {$urandom, $urandom};
                b_data[k]  = {$urandom, $urandom};
            end
            step();
            check($sformatf("alt s_data #%0d", i), s_data[0], i % 2);
            check($sformatf("burst3 s_data #%0d", i), s_data[1], (i / 3) % 2);
            check($sformatf("alt z_data #%0d", i), z_data[0], (i % 2) ? b_data[0] : a_data[0]);
        end

        // S stalled after one grant: Z drains, no grants until S_ready returns.
        do_reset();
        a_valid[0] = 1;
        b_valid[0] = 1;
        step();
        s_ready[0] = 0;
        repeat (3) step();
        check("stall z_valid", z_valid[0], 0);
        check("stall s_valid", s_valid[0], 1);
        s_ready[0] = 1;
        step();
        check("resume s_data", s_data[0], 1);

        // Lone requester A for 5 tokens on BURST=2, then B wins the first contest.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a_valid[2] = 1;
            a_data[2]  = 64'(i + 1);
            step();
            check($sformatf("lone s_data #%0d", i), s_data[2], 0);
        end
        b_valid[2] = 1;
        b_data[2]  = 64'hB0B0;
        step();
        check("lone then B", s_data[2], 1);
        check("lone then B data", z_data[2], 64'hB0B0);

        // Async reset between edges mid-stream.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a_valid[k] = 1;
            b_valid[k] = 1;
        end
        repeat (3) step();
        @(posedge clk);
        #3;
        reset_n = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst z_valid[%0d]", k), z_valid[k], 0);
            check($sformatf("midrst s_valid[%0d]", k), s_valid[k], 0);
            check($sformatf("midrst a_ready[%0d]", k), a_ready[k], 0);
        end
        @(negedge clk);
        model_reset();
        reset_n = 1;
        step();
        for (int k = 0; k < 3; k++) check($sformatf("post-rst order[%0d]", k), s_data[k], 0);

        // Random traffic with valid-hold on the sources and random backpressure.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (!(a_valid[k] && !acc_a[k])) begin
                    a_valid[k] = 1'($urandom_range(0, 1));
                    a_data[k]  = {$urandom, $urandom};
                end
                if (!(b_valid[k] && !acc_b[k])) begin
                    b_valid[k] = 1'($urandom_range(0, 1));
                    b_data[k]  = {$urandom, $urandom};
                end
                z_ready[k] = ($urandom_range(0, 3) != 0);
                s_ready[k] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
